// File: rtl/seq_restoring_divider_pkg.sv
// Shared constants for the sequential restoring divider.
//   state_t          : FSM encoding (IDLE / RUN / DONE)
//   DBZ_QUOTIENT_BIT : fill bit replicated across the quotient on divide-by-zero
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Divide-by-zero reports an all-ones quotient of whatever width N is.
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division step, purely combinational.
//   r_shift : W-bit shifted partial remainder {R, next dividend bit}
//   divisor : W-bit zero-extended divisor
//   r_next  : W-1 bit next remainder (difference if no borrow, else r_shift)
//   q_bit   : quotient bit = carry-out of r_shift - divisor (1 means r_shift >= divisor)
// The subtraction is a gate-level ripple chain: r_shift + ~divisor + 1.
module seq_restoring_divider_div_step #(
  parameter int W = 9
) (
  input  logic [W-1:0] r_shift,
  input  logic [W-1:0] divisor,
  output logic [W-2:0] r_next,
  output logic         q_bit
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic b_n;
    assign b_n          = ~divisor[i];
    assign carry[i + 1] = (r_shift[i] & b_n) | (carry[i] & (r_shift[i] ^ b_n));
    // The next remainder is always below the divisor, so it fits in W-1 bits;
    // the top difference bit is never needed, only the carry it produces.
    if (i < W - 1) begin : g_sum
      logic diff;
      assign diff      = r_shift[i] ^ b_n ^ carry[i];
      assign r_next[i] = carry[W] ? diff : r_shift[i];
    end
  end

  assign q_bit = carry[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned N-bit sequential restoring divider, one trial subtraction per clock.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : request; accepted in IDLE or DONE, ignored in RUN
//   dividend    : numerator, sampled on the accepting edge
//   divisor     : denominator, sampled on the accepting edge
//   busy        : high while iterating (N cycles)
//   done        : one-cycle pulse when new results are presented
//   quotient    : registered quotient (all ones on divide-by-zero)
//   remainder   : registered remainder (dividend on divide-by-zero)
//   div_by_zero : registered divide-by-zero flag
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [N-1:0]       d_q, d_d;
  logic [N-1:0]       q_q, q_d;
  // Working remainder is kept at N bits: after every step R < D <= 2^N-1,
  // and the extra bit only exists in the shifted value fed to the step.
  logic [N-1:0]       r_q, r_d;
  logic [N-1:0]       quotient_q, quotient_d;
  logic [N-1:0]       remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [N:0]         r_shift;
  logic [N-1:0]       step_r;
  logic               step_q_bit;

  assign r_shift = {r_q, q_q[N-1]};

  seq_restoring_divider_div_step #(
    .W (N + 1)
  ) u_div_step (
    .r_shift (r_shift),
    .divisor ({1'b0, d_q}),
    .r_next  (step_r),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    d_d         = d_q;
    q_d         = q_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_RUN: begin
        q_d     = {q_q[N-2:0], step_q_bit};
        r_d     = step_r;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          quotient_d  = {q_q[N-2:0], step_q_bit};
          remainder_d = step_r;
          dbz_d       = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE always falls back to IDLE.
        state_d = ST_IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = {N{DBZ_QUOTIENT_BIT}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_RUN;
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            count_d = CNT_W'(N);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      d_q         <= d_d;
      q_q         <= q_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  res_t last_res = '0;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    res_t e;
    if (b == 0) begin
      e.q = {N{1'b1}}; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: checks every presented result against the scoreboard and
  // verifies that outputs hold between done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_res = '0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_dbz", int'(div_by_zero), 0);
    end else if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: quotient %0d remainder %0d with empty scoreboard", quotient, remainder);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
        last_res = e;
      end
    end else begin
      chk("hold_quotient", int'(quotient), int'(last_res.q));
      chk("hold_remainder", int'(remainder), int'(last_res.r));
      chk("hold_dbz", int'(div_by_zero), int'(last_res.dbz));
    end
  end

  // Wait for done, counting cycles and busy cycles since the accept edge.
  task automatic wait_done(inout int k, inout int bc);
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) bc++;
      k++;
      if (k > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: no done after %0d cycles", k);
        break;
      end
    end
  endtask

  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b);
    int k;
    int bc;
    k = 0; bc = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(a, b));
    start = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    wait_done(k, bc);
    chk("latency", k, (b == 0) ? 0 : N);
    chk("busy_cycles", bc, (b == 0) ? 0 : N);
  endtask

  initial begin
    int k;
    int bc;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(8'd100, 8'd7);
    do_div(8'd255, 8'd1);
    do_div(8'd5, 8'd9);
    do_div(8'd255, 8'd255);
    do_div(8'hA5, 8'd0);
    do_div(8'd5, 8'd9);

    // start re-pulsed mid-RUN must be ignored
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(8'd200, 8'd3));
    start = 1'b0;
    k = 0; bc = 0;
    repeat (3) begin
      @(negedge clk); k++; if (busy) bc++;
    end
    dividend = 8'd9; divisor = 8'd2; start = 1'b1;
    @(negedge clk); k++; if (busy) bc++;
    start = 1'b0;
    k--; bc--;  // wait_done counts from the cycle it first samples
    k++; bc++;
    wait_done(k, bc);
    chk("ignored_start_latency", k, N);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(8'd200, 8'd3));
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_quotient", int'(quotient), 0);
    chk("async_remainder", int'(remainder), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_div(8'd50, 8'd5);

    // back-to-back: start held high, new operands presented in the DONE cycle
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(8'd100, 8'd7));
    k = 0; bc = 0;
    wait_done(k, bc);
    chk("b2b_first_latency", k, N);
    dividend = 8'd77; divisor = 8'd10;
    @(posedge clk);
    #1;
    exp_q.push_back(model(8'd77, 8'd10));
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy_resumes", int'(busy), 1);
    k = 1; bc = 1;
    wait_done(k, bc);
    chk("b2b_second_latency", k, N);

    // randomized operations, occasionally dividing by zero
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      do_div(a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
